// File: rtl/cpu_dump_pkg.sv
// rtl/cpu_dump_pkg.sv - shared types and frame layout constants for the CPU state dumper
// Purpose: FSM state encoding and fixed snapshot frame indices.
// Ports: none (package).
package cpu_dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_REGS = 2'd2,
        ST_MEM  = 2'd3
    } dump_state_e;

    // Frame layout: 4 header words, 32 registers, 8 data-memory words.
    localparam logic [5:0] DUMP_WORDS = 6'd44;
    localparam logic [5:0] IDX_REGS   = 6'd4;
    localparam logic [5:0] IDX_MEM    = 6'd36;
    localparam logic [5:0] IDX_LAST   = 6'd43;

    // Header word offsets within the frame.
    localparam logic [5:0] OFF_CYC = 6'd0;
    localparam logic [5:0] OFF_STL = 6'd1;
    localparam logic [5:0] OFF_FLS = 6'd2;
    localparam logic [5:0] OFF_PC  = 6'd3;

endpackage

// File: rtl/event_counter.sv
// rtl/event_counter.sv - 32-bit wrapping event counter with sync clear and enable
// Purpose: counts qualified CPU events; exposes the post-update value so a
//          snapshot taken on the same edge includes this cycle's event.
// Ports:
//   clk_i         - clock
//   clr_i         - synchronous clear (active-high)
//   en_i          - increment enable
//   count_next_o  - value the counter holds after the coming edge
module event_counter (
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [31:0] count_next_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 32'd0;
        end else if (en_i) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_next_o = count_d;

endmodule

// File: rtl/cpu_state_dumper.sv
// rtl/cpu_state_dumper.sv - freezes the CPU and streams a 44-word state snapshot
// Purpose: counts cycles/stalls/flushes, and on request halts the CPU and
//          streams {cyc, stl, fls, pc, R0..R31, dmem[0..7]} over valid/ready.
// Ports:
//   clk_i, rst_i                    - clock, sync active-high reset
//   start_i, stall_i, flush_i, pc_i - CPU status inputs
//   dump_req_i                      - dump request (honoured only when idle)
//   reg_addr_o / reg_data_i         - register-file debug read port
//   dmem_addr_o / dmem_data_i       - data-memory debug read port
//   halt_o, busy_o                  - CPU freeze / dump in progress
//   dump_valid_o, dump_data_o, dump_last_o, dump_ready_i - snapshot stream
module cpu_state_dumper
    import cpu_dump_pkg::*;
#(
    parameter int DMEM_WORDS = 8,
    parameter int NUM_REGS   = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic        dump_req_i,
    output logic [4:0]  reg_addr_o,
    input  logic [31:0] reg_data_i,
    output logic [31:0] dmem_addr_o,
    input  logic [31:0] dmem_data_i,
    output logic        halt_o,
    output logic        busy_o,
    output logic        dump_valid_o,
    output logic [31:0] dump_data_o,
    output logic        dump_last_o,
    input  logic        dump_ready_i
);

    localparam logic [5:0] MEM_START = 6'(int'(IDX_REGS) + NUM_REGS);
    localparam logic [5:0] LAST_IDX  = 6'(int'(MEM_START) + DMEM_WORDS - 1);

    dump_state_e state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] snap_cyc_q, snap_cyc_d;
    logic [31:0] snap_stl_q, snap_stl_d;
    logic [31:0] snap_fls_q, snap_fls_d;
    logic [31:0] snap_pc_q, snap_pc_d;

    logic        halt;
    logic        cnt_en;
    logic [31:0] cyc_next, stl_next, fls_next;
    logic [5:0]  mem_off;

    assign halt   = (state_q != ST_IDLE);
    assign cnt_en = start_i && !halt;

    event_counter u_cyc (.clk_i(clk_i), .clr_i(rst_i), .en_i(cnt_en),            .count_next_o(cyc_next));
    event_counter u_stl (.clk_i(clk_i), .clr_i(rst_i), .en_i(cnt_en && stall_i), .count_next_o(stl_next));
    event_counter u_fls (.clk_i(clk_i), .clr_i(rst_i), .en_i(cnt_en && flush_i), .count_next_o(fls_next));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_cyc_d = snap_cyc_q;
        snap_stl_d = snap_stl_q;
        snap_fls_d = snap_fls_q;
        snap_pc_d  = snap_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (dump_req_i) begin
                    state_d    = ST_HDR;
                    idx_d      = 6'd0;
                    // Post-update values: the accepting cycle's events are included.
                    snap_cyc_d = cyc_next;
                    snap_stl_d = stl_next;
                    snap_fls_d = fls_next;
                    snap_pc_d  = pc_i;
                end
            end
            default: begin
                if (dump_ready_i) begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = 6'd0;
                    end else if (idx_q == MEM_START - 6'd1) begin
                        state_d = ST_MEM;
                    end else if (idx_q == IDX_REGS - 6'd1) begin
                        state_d = ST_REGS;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= 6'd0;
            snap_cyc_q <= 32'd0;
            snap_stl_q <= 32'd0;
            snap_fls_q <= 32'd0;
            snap_pc_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_cyc_q <= snap_cyc_d;
            snap_stl_q <= snap_stl_d;
            snap_fls_q <= snap_fls_d;
            snap_pc_q  <= snap_pc_d;
        end
    end

    // Addresses come only from registered idx, so they hold while the sink stalls.
    assign mem_off = idx_q - MEM_START;

    always_comb begin
        reg_addr_o  = 5'd0;
        dmem_addr_o = 32'd0;
        dump_data_o = 32'd0;
        case (state_q)
            ST_HDR: begin
                case (idx_q)
                    OFF_CYC: dump_data_o = snap_cyc_q;
                    OFF_STL: dump_data_o = snap_stl_q;
                    OFF_FLS: dump_data_o = snap_fls_q;
                    default: dump_data_o = snap_pc_q;
                endcase
            end
            ST_REGS: begin
                // idx 4..35 maps modulo 32 onto 0..31.
                reg_addr_o  = idx_q[4:0] - IDX_REGS[4:0];
                dump_data_o = reg_data_i;
            end
            ST_MEM: begin
                dmem_addr_o = {24'd0, mem_off, 2'b00};
                dump_data_o = dmem_data_i;
            end
            default: ;
        endcase
    end

    assign halt_o       = halt;
    assign busy_o       = halt;
    assign dump_valid_o = halt;
    assign dump_last_o  = halt && (idx_q == LAST_IDX);

endmodule
